// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle sequencer: FSM state encoding,
// the four accepted major opcodes and the ALU operation codes.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_NONE   = 4'b0000;
  localparam logic [3:0] ALU_RTYPE  = 4'b0000;
  localparam logic [3:0] ALU_MEM    = 4'b0001;
  localparam logic [3:0] ALU_BRANCH = 4'b0010;

endpackage

// File: rtl/seq_opcode_decode.sv
// Classifies the major opcode of the held instruction into one of the
// instruction classes the sequencer knows; anything else is illegal.
module seq_opcode_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_illegal
);

  assign is_rtype   = (opcode == OPC_RTYPE);
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_illegal = ~(is_rtype | is_load | is_store | is_branch);

endmodule

// File: rtl/multicycle_sequencer.sv
// Moore FSM that steps one instruction through FETCH/DECODE/EXEC/MEM/WB,
// with a per-request wait timeout and a sticky, absorbing FAULT state.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic        retired,
  output logic        fault,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  // Handshake: a request output stays high for its whole FETCH/MEM state;
  // the matching ready is only looked at while in that state, and the
  // request is accepted in the same cycle ready is seen high.
  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] pc_inc;
  logic [3:0]  exec_alu_op;
  logic        is_rtype, is_load, is_store, is_branch, is_illegal;

  seq_opcode_decode u_decode (
    .opcode     (instr[6:0]),
    .is_rtype   (is_rtype),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_illegal (is_illegal)
  );

  assign pc_inc      = pc + 32'd4;
  assign exec_alu_op = is_rtype ? ALU_RTYPE : (is_branch ? ALU_BRANCH : ALU_MEM);
  assign dbg_state   = state;

  // Outputs are registered alongside the state, so each transition also
  // sets the outputs that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      alu_op   <= ALU_NONE;
      rf_we    <= 1'b0;
      retired  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      retired <= 1'b0;
      case (state)
        S_BOOT: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          // Ready seen on the last allowed wait cycle still wins over fault.
          if (imem_ready) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else if (wait_cnt == TIMEOUT) begin
            wait_cnt <= '0;
            imem_req <= 1'b0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_illegal) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            alu_op <= exec_alu_op;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            pc       <= branch_taken ? branch_target : pc_inc;
            alu_op   <= ALU_NONE;
            imem_req <= 1'b1;
            retired  <= 1'b1;
            state    <= S_FETCH;
          end else if (is_load || is_store) begin
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
            state    <= S_MEM;
          end else begin
            alu_op <= ALU_NONE;
            rf_we  <= 1'b1;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            alu_op   <= ALU_NONE;
            if (is_store) begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              retired  <= 1'b1;
              state    <= S_FETCH;
            end else begin
              rf_we <= 1'b1;
              state <= S_WB;
            end
          end else if (wait_cnt == TIMEOUT) begin
            wait_cnt <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            alu_op   <= ALU_NONE;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          rf_we    <= 1'b0;
          pc       <= pc_inc;
          imem_req <= 1'b1;
          retired  <= 1'b1;
          state    <= S_FETCH;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          fault <= 1'b1;
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each
// instruction into per-cycle stimulus and expected outputs.
module tb_multicycle_sequencer;
  import riscv_pkg::*;

  localparam int          TIMEOUT = 15;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic [31:0] imem_rdata = '0, branch_target = '0;
  logic        imem_req, dmem_req, dmem_we, rf_we, retired, fault;
  logic [31:0] pc, instr;
  logic [3:0]  alu_op;
  logic [2:0]  dbg_state;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_retired, w_fault;
  logic [31:0] w_pc, w_instr;
  logic [3:0]  w_alu_op;
  logic [2:0]  w_dbg_state;

  multicycle_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .instr(instr), .alu_op(alu_op),
    .rf_we(rf_we), .retired(retired), .fault(fault), .dbg_state(dbg_state)
  );

  multicycle_sequencer #(.RESET_PC(WRAP_PC), .MEM_TIMEOUT(TIMEOUT)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(w_pc), .instr(w_instr), .alu_op(w_alu_op),
    .rf_we(w_rf_we), .retired(w_retired), .fault(w_fault), .dbg_state(w_dbg_state)
  );

  // ---------------- model state and scoreboard ----------------
  typedef struct packed {
    logic        i_rdy;
    logic [31:0] i_data;
    logic        d_rdy;
    logic        b_tk;
    logic [31:0] b_tgt;
  } stim_t;

  stim_t       stim_q[$];
  logic [73:0] exp_q[$];
  logic [31:0] m_pc, m_instr;
  bit          m_ret;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rf_cnt = 0, ret_cnt = 0, dreq_cnt = 0, dwe_cnt = 0;

  function automatic logic [73:0] pack_out(logic ireq, logic dreq, logic dwe, logic [3:0] alu,
                                           logic rf, logic ret, logic flt,
                                           logic [31:0] p, logic [31:0] ins);
    return {ireq, dreq, dwe, alu, rf, ret, flt, p, ins};
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.i_rdy  = 1'($urandom_range(0, 1));
    s.i_data = $urandom;
    s.d_rdy  = 1'($urandom_range(0, 1));
    s.b_tk   = 1'($urandom_range(0, 1));
    s.b_tgt  = $urandom;
    return s;
  endfunction

  // 0 illegal, 1 R-type, 2 load, 3 store, 4 branch
  function automatic int classify(logic [31:0] w);
    case (w[6:0])
      7'h33:   return 1;
      7'h03:   return 2;
      7'h23:   return 3;
      7'h63:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic push(input stim_t s, input logic [73:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic plan_fault(input int n);
    for (int k = 0; k < n; k++) push(rnd_stim(), pack_out(0, 0, 0, 4'h0, 0, 0, 1, m_pc, m_instr));
  endtask

  // A request may see TIMEOUT ready-low cycles; ready on the next cycle is
  // still taken, a further low cycle faults.
  task automatic plan_fetch(input logic [31:0] word, input int waits);
    stim_t s;
    for (int k = 0; k <= waits; k++) begin
      s = rnd_stim();
      s.i_rdy = (k == waits);
      if (k == waits) s.i_data = word;
      push(s, pack_out(1, 0, 0, 4'h0, 0, (k == 0) && m_ret, 0, m_pc, m_instr));
    end
    m_ret   = 0;
    m_instr = word;
  endtask

  task automatic plan_timeout(input int nf);
    stim_t s;
    for (int k = 0; k <= TIMEOUT; k++) begin
      s = rnd_stim();
      s.i_rdy = 1'b0;
      push(s, pack_out(1, 0, 0, 4'h0, 0, (k == 0) && m_ret, 0, m_pc, m_instr));
    end
    m_ret = 0;
    plan_fault(nf);
  endtask

  task automatic plan_wb();
    push(rnd_stim(), pack_out(0, 0, 0, 4'h0, 1, 0, 0, m_pc, m_instr));
    m_pc  = m_pc + 32'd4;
    m_ret = 1;
  endtask

  task automatic plan_instr(input logic [31:0] word, input int fwait, input int mwait,
                            input logic tk, input logic [31:0] tgt);
    int cls;
    stim_t s;
    logic [3:0] alu;
    plan_fetch(word, fwait);
    cls = classify(word);
    push(rnd_stim(), pack_out(0, 0, 0, 4'h0, 0, 0, 0, m_pc, m_instr));
    if (cls == 0) begin
      plan_fault(6);
      return;
    end
    alu = (cls == 1) ? 4'h0 : ((cls == 4) ? 4'h2 : 4'h1);
    s = rnd_stim();
    s.b_tk  = tk;
    s.b_tgt = tgt;
    push(s, pack_out(0, 0, 0, alu, 0, 0, 0, m_pc, m_instr));
    if (cls == 4) begin
      m_pc  = tk ? tgt : m_pc + 32'd4;
      m_ret = 1;
    end else if (cls == 1) begin
      plan_wb();
    end else begin
      for (int k = 0; k <= mwait; k++) begin
        s = rnd_stim();
        s.d_rdy = (k == mwait);
        push(s, pack_out(0, 1, cls == 3, 4'h1, 0, 0, 0, m_pc, m_instr));
      end
      if (cls == 3) begin
        m_pc  = m_pc + 32'd4;
        m_ret = 1;
      end else begin
        plan_wb();
      end
    end
  endtask

  // ---------------- compare process / driver ----------------
  task automatic run_cycles(input int limit);
    logic [73:0] e, act;
    stim_t s;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      act = {imem_req, dmem_req, dmem_we, alu_op, rf_we, retired, fault, pc, instr};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle %0d outputs (req,dreq,we,alu,rf,ret,flt,pc,instr): got %h expected %h",
                 cyc, act, e);
      end
      rf_cnt   += int'(rf_we);
      ret_cnt  += int'(retired);
      dreq_cnt += int'(dmem_req);
      dwe_cnt  += int'(dmem_we);
      imem_ready    = s.i_rdy;
      imem_rdata    = s.i_data;
      dmem_ready    = s.d_rdy;
      branch_taken  = s.b_tk;
      branch_target = s.b_tgt;
      cyc++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    rf_cnt = 0; ret_cnt = 0; dreq_cnt = 0; dwe_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    exp_q.delete();
    stim_q.delete();
    repeat (2) @(negedge clk);
    check("reset outputs", {imem_req, dmem_req, dmem_we, alu_op, rf_we, retired, fault, pc[31:8]}, 32'h0);
    check("reset pc/instr", pc | instr, 32'h0);
    check("reset state", 32'(dbg_state), 32'(S_BOOT));
    rst_n   = 1'b1;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_ret   = 0;
    push(rnd_stim(), pack_out(0, 0, 0, 4'h0, 0, 0, 0, m_pc, m_instr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [12:0] wrap_ctl;

    do_reset();
    check("wrap reset pc", w_pc, WRAP_PC);

    clr_cnt();
    plan_instr(32'h00B50533, 0, 0, 1'b1, 32'h0000_0040);
    run_cycles(1000);
    check("rtype pc", pc, 32'h4);
    check("rtype rf_we count", rf_cnt, 1);
    check("rtype retired pulse", 32'(retired), 1);
    check("wrap pc wraps", w_pc, 32'h0);
    wrap_ctl = {w_imem_req, w_dmem_req, w_dmem_we, w_alu_op, w_rf_we, w_retired, w_fault, w_dbg_state};
    check("wrap controls", 32'(wrap_ctl), 32'({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd1}));
    check("wrap instr", w_instr, 32'h00B50533);

    clr_cnt();
    plan_instr(32'h0005A503, 2, 3, 1'b0, 32'h0);
    run_cycles(1000);
    check("load dmem_req cycles", dreq_cnt, 4);
    check("load dmem_we cycles", dwe_cnt, 0);
    check("load rf_we count", rf_cnt, 1);
    check("load pc", pc, 32'h8);

    clr_cnt();
    plan_instr(32'h00A5A023, 0, 0, 1'b1, 32'h0000_0800);
    run_cycles(1000);
    check("store pc", pc, 32'hC);
    check("store rf_we count", rf_cnt, 0);
    check("store dmem_we cycles", dwe_cnt, 1);

    clr_cnt();
    plan_instr(32'h00B50463, 0, 0, 1'b1, 32'h0000_0100);
    run_cycles(1000);
    check("branch taken pc", pc, 32'h100);
    check("branch rf_we count", rf_cnt, 0);

    plan_instr(32'h00B50463, TIMEOUT, 0, 1'b0, 32'h0000_0200);
    run_cycles(1000);
    check("late fetch ready pc", pc, 32'h104);
    check("late fetch ready no fault", 32'(fault), 0);

    plan_instr(32'h40B50533, 1, 0, 1'b0, 32'h0);
    plan_instr(32'h00A5A023, 0, TIMEOUT, 1'b0, 32'h0);
    run_cycles(1000);
    check("late mem ready pc", pc, 32'h10C);
    check("late mem ready no fault", 32'(fault), 0);

    plan_instr(32'h0000007F, 0, 0, 1'b0, 32'h0);
    run_cycles(1000);
    check("illegal fault", 32'(fault), 1);
    check("illegal state", 32'(dbg_state), 32'(S_FAULT));
    check("illegal pc frozen", pc, 32'h10C);

    // Fetch never answered.
    do_reset();
    plan_timeout(10);
    run_cycles(1000);
    check("timeout fault", 32'(fault), 1);
    check("timeout requests", {30'h0, imem_req, dmem_req}, 32'h0);

    // Reset in the middle of a store's MEM wait.
    do_reset();
    plan_instr(32'h00B50533, 0, 0, 1'b0, 32'h0);
    plan_instr(32'h00A5A023, 0, 10, 1'b0, 32'h0);
    run_cycles(1 + 4 + 6);
    check("mid-store dmem_req", 32'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async drop dmem_req", {30'h0, dmem_req, rf_we}, 32'h0);
    check("async pc", pc, 32'h0);
    do_reset();
    run_cycles(1);
    check("boot then fetch", 32'(dbg_state), 32'(S_FETCH));
    plan_instr(32'h00B50533, 0, 0, 1'b0, 32'h0);
    run_cycles(1000);
    check("after reset rtype pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles per memory request before fault (range 1..255).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 dmem_req  output  1  data memory request.
REQ-009 dmem_we  output  1  data request is a store.
REQ-010 dmem_ready  input  1  data access complete.
REQ-011 branch_taken  input  1  branch condition from ALU, sampled in EXEC.
REQ-012 branch_target  input  32  branch destination from datapath, sampled in EXEC.
REQ-013 pc  output  32  current instruction address.
REQ-014 instr  output  32  instruction register.
REQ-015 alu_op  output  4  ALU operation select.
REQ-016 rf_we  output  1  register-file write strobe.
REQ-017 retired  output  1  one-cycle pulse per completed instruction.
REQ-018 fault  output  1  sticky fault flag.

Function
REQ-019 SHALL be a Moore FSM with states BOOT, FETCH, DECODE, EXEC, MEM, WB, FAULT; all outputs are decoded from state and registers only.
REQ-020 BOOT SHALL last exactly one cycle, then go to FETCH.
REQ-021 FETCH: imem_req=1; on imem_ready=1, load instr<=imem_rdata and go to DECODE; ready in the same cycle as req is accepted; imem_ready is ignored outside FETCH.
REQ-022 DECODE (1 cycle): opcode=instr[6:0]; 0110011, 0000011, 0100011 and 1100011 go to EXEC; any other opcode goes to FAULT.
REQ-023 EXEC (1 cycle): alu_op=0000 for R-type, 0001 for load/store, 0010 for branch; alu_op=0000 in all other states except MEM (holds 0001).
REQ-024 EXEC next-state rules:
- R-type -> WB.
- Load or store -> MEM.
- Branch: pc<=branch_taken ? branch_target : pc+4, retired=1 on the following cycle's entry into FETCH, then go to FETCH.
REQ-025 MEM: dmem_req=1, dmem_we=1 only for store; on dmem_ready a load goes to WB; a store does pc<=pc+4, pulses retired, and goes to FETCH.
REQ-026 WB (1 cycle): rf_we=1, pc<=pc+4, retired=1, then go to FETCH; rf_we SHALL be 0 in every other state.
REQ-027 retired SHALL be a registered one-cycle pulse asserted in the first FETCH cycle after completion.
REQ-028 Wait counter SHALL increment each FETCH/MEM cycle with ready low, and clear on state exit.
REQ-029 When the wait counter reaches MEM_TIMEOUT with ready still low, the FSM SHALL go to FAULT; ready arriving in that same cycle wins and no fault is raised.
REQ-030 FAULT SHALL be absorbing until reset: fault=1; imem_req, dmem_req, rf_we and retired are 0; pc and instr are frozen.
REQ-031 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 Minimum latency with zero-wait memory: branch 3 cycles, R-type and store 4, load 5 (FETCH entry to next FETCH entry).

Reset
REQ-033 While rst_n=0 the block SHALL be in state BOOT with pc=RESET_PC, instr=0, wait counter=0 and fault=0.
REQ-034 While rst_n=0, imem_req, dmem_req, dmem_we, rf_we and retired SHALL be 0 and alu_op SHALL be 0000.
REQ-035 Reset asserted mid-transaction SHALL abandon the request immediately; no write strobe SHALL be emitted.

Structure
REQ-036 Opcode constants, alu_op codes and the state encoding SHALL live in shared package riscv_pkg.
REQ-037 Opcode classification (R/load/store/branch/illegal) SHALL be a sub-module, seq_opcode_decode.

Verification
REQ-038 Reset, then R-type 32'h00B50533 with imem_ready immediate -> rf_we pulses in cycle 4 of the instruction, pc 0->4, one retired pulse.
REQ-039 Load 32'h0005A503 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then rf_we=1, pc=4.
REQ-040 Branch with branch_taken=1, branch_target=32'h0000_0100 -> pc=32'h100, rf_we never asserted.
REQ-041 imem_ready held low -> FAULT after 15 wait cycles; fault stays 1; all requests 0 until rst_n is asserted.
REQ-042 Opcode 7'b1111111 -> FAULT from DECODE; a second case with RESET_PC=32'hFFFF_FFFC and an R-type -> pc wraps to 0.
REQ-043 rst_n pulsed low during MEM of a store -> dmem_req drops asynchronously; pc=RESET_PC; BOOT is followed by FETCH.
